// File: rtl/sched_microseq_if.sv
// ---------------------------------------------------------------------------
// sched_microseq_if
// Bundles every non-clock/reset signal of the microcoded schedule sequencer.
//
//   Control in : start, stall, abort
//   Program in : prog_we, prog_addr[AW], prog_data[UW]
//   Status out : prog_err, op_ready, result_en, done_next, overrun,
//                step_idx[AW]
//   Datapath   : alu1_sel1/alu1_sel2[SEL_W], alu1_op,
//                mul1_sel1/mul1_sel2[SEL_W], mul1_op, reg_en[NUM_REGS]
//   Optional   : run_cycles[16] when SCHED_PERF_EN is defined
//
// Modports: master = the controller/testbench side, slave = the sequencer.
// ---------------------------------------------------------------------------
interface sched_microseq_if #(
    parameter int SEL_W     = 4,
    parameter int NUM_REGS  = 8,
    parameter int MAX_STEPS = 16
);
    localparam int AW = $clog2(MAX_STEPS);
    localparam int UW = 3 + 4 * SEL_W + NUM_REGS;

    logic                start;
    logic                stall;
    logic                abort;
    logic                prog_we;
    logic [AW-1:0]       prog_addr;
    logic [UW-1:0]       prog_data;

    logic                prog_err;
    logic                op_ready;
    logic                result_en;
    logic                done_next;
    logic                overrun;
    logic [AW-1:0]       step_idx;
    logic [SEL_W-1:0]    alu1_sel1;
    logic [SEL_W-1:0]    alu1_sel2;
    logic                alu1_op;
    logic [SEL_W-1:0]    mul1_sel1;
    logic [SEL_W-1:0]    mul1_sel2;
    logic                mul1_op;
    logic [NUM_REGS-1:0] reg_en;
`ifdef SCHED_PERF_EN
    logic [15:0]         run_cycles;
`endif

    modport master (
`ifdef SCHED_PERF_EN
        input  run_cycles,
`endif
        output start, stall, abort, prog_we, prog_addr, prog_data,
        input  prog_err, op_ready, result_en, done_next, overrun, step_idx,
        input  alu1_sel1, alu1_sel2, alu1_op, mul1_sel1, mul1_sel2, mul1_op,
        input  reg_en
    );

    modport slave (
`ifdef SCHED_PERF_EN
        output run_cycles,
`endif
        input  start, stall, abort, prog_we, prog_addr, prog_data,
        output prog_err, op_ready, result_en, done_next, overrun, step_idx,
        output alu1_sel1, alu1_sel2, alu1_op, mul1_sel1, mul1_sel2, mul1_op,
        output reg_en
    );
endinterface

// File: rtl/sched_microseq.sv
// ---------------------------------------------------------------------------
// sched_microseq
// Programmable schedule sequencer. Each step of an ALU/MUL schedule is a
// microcode word held in an internal table; a run walks the table from
// step 0 until a word with the last flag set, or until the table end
// (flagged as overrun). Stall freezes the step, abort drops back to IDLE.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (also clears the microcode table)
//   bus    sched_microseq_if.slave: start/stall/abort, microcode write port,
//          status (op_ready, result_en, done_next, overrun, step_idx,
//          prog_err) and the decoded datapath controls.
//
// Microcode word, LSB first:
//   [0] last, [1] alu_op, [2] mul_op, alu_sel1, alu_sel2, mul_sel1,
//   mul_sel2 (SEL_W each), reg_en (NUM_REGS).
//
// Build option: define SCHED_PERF_EN to add the run_cycles counter.
// ---------------------------------------------------------------------------
module sched_microseq #(
    parameter int SEL_W     = 4,
    parameter int NUM_REGS  = 8,
    parameter int MAX_STEPS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    sched_microseq_if.slave  bus
);
    localparam int AW = $clog2(MAX_STEPS);
    localparam logic [AW-1:0] LAST_IDX = AW'(MAX_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Declared MSB first so that 'last' lands on bit 0 of the word.
    typedef struct packed {
        logic [NUM_REGS-1:0] reg_en;
        logic [SEL_W-1:0]    mul_sel2;
        logic [SEL_W-1:0]    mul_sel1;
        logic [SEL_W-1:0]    alu_sel2;
        logic [SEL_W-1:0]    alu_sel1;
        logic                mul_op;
        logic                alu_op;
        logic                last;
    } ucode_t;

    state_t        state_q, state_d;
    logic [AW-1:0] step_q, step_d;
    logic          overrun_q, overrun_d;
    logic          drive;
    logic          wr_en;
    ucode_t        table_q [MAX_STEPS];
    ucode_t        cur;

    // Writes land only while idle, so a running schedule never sees its
    // own microcode change underneath it.
    assign wr_en        = bus.prog_we && (state_q == S_IDLE);
    assign bus.prog_err = bus.prog_we && (state_q != S_IDLE);

    // NOTE: the table must read as all-zero after reset, so it is built
    // from resettable flops; a table without that need would drop the
    // reset branch and map to RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_STEPS; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en) begin
            table_q[bus.prog_addr] <= ucode_t'(bus.prog_data);
        end
    end

    assign cur = table_q[step_q];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        overrun_d     = overrun_q;
        drive         = 1'b0;
        bus.op_ready  = 1'b0;
        bus.result_en = 1'b0;
        bus.done_next = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.op_ready = 1'b1;
                if (bus.start) begin
                    state_d   = S_RUN;
                    step_d    = '0;
                    overrun_d = 1'b0;
                end
            end

            S_RUN: begin
                // Priority: abort, then stall, then last/overrun/advance.
                if (bus.abort) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end else if (!bus.stall) begin
                    drive = 1'b1;
                    if (cur.last) begin
                        bus.result_en = 1'b1;
                        state_d       = S_DONE;
                    end else if (step_q == LAST_IDX) begin
                        // Ran off the table end: close the run anyway.
                        bus.result_en = 1'b1;
                        overrun_d     = 1'b1;
                        state_d       = S_DONE;
                    end else begin
                        step_d = step_q + AW'(1);
                    end
                end
            end

            S_DONE: begin
                // Stall has no effect here; abort suppresses the pulse.
                if (!bus.abort) begin
                    bus.done_next = 1'b1;
                end
                state_d = S_IDLE;
                step_d  = '0;
            end

            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase

        bus.alu1_sel1 = drive ? cur.alu_sel1 : '0;
        bus.alu1_sel2 = drive ? cur.alu_sel2 : '0;
        bus.alu1_op   = drive ? cur.alu_op   : 1'b0;
        bus.mul1_sel1 = drive ? cur.mul_sel1 : '0;
        bus.mul1_sel2 = drive ? cur.mul_sel2 : '0;
        bus.mul1_op   = drive ? cur.mul_op   : 1'b0;
        bus.reg_en    = drive ? cur.reg_en   : '0;
    end

    assign bus.step_idx = step_q;
    assign bus.overrun  = overrun_q;

`ifdef SCHED_PERF_EN
    // Counts every RUN cycle including stalls; saturates rather than wraps.
    logic [15:0] run_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cycles_q <= '0;
        end else if (state_q == S_IDLE && bus.start) begin
            run_cycles_q <= '0;
        end else if (state_q == S_RUN && run_cycles_q != 16'hFFFF) begin
            run_cycles_q <= run_cycles_q + 16'd1;
        end
    end

    assign bus.run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_sched_microseq.sv
// ---------------------------------------------------------------------------
// tb_sched_microseq
// Self-checking bench for sched_microseq: a table of per-cycle vectors
// (start/stall/abort in, expected status and datapath fields out) covers
// the normal, stalled and aborted runs of a 6-step schedule; hand-written
// sequences cover dropped writes, async reset mid-run and table overrun.
// Build option: SCHED_PERF_EN enables run_cycles checks.
// ---------------------------------------------------------------------------
module tb_sched_microseq;
    localparam int SEL_W     = 4;
    localparam int NUM_REGS  = 8;
    localparam int MAX_STEPS = 16;

    logic clk;
    logic rst_n;

    sched_microseq_if #(
        .SEL_W(SEL_W), .NUM_REGS(NUM_REGS), .MAX_STEPS(MAX_STEPS)
    ) bus ();

    sched_microseq #(
        .SEL_W(SEL_W), .NUM_REGS(NUM_REGS), .MAX_STEPS(MAX_STEPS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    // Programmed schedule (6 steps, last at step 5).
    typedef struct {
        logic       aop;
        logic       mop;
        logic [3:0] a1;
        logic [3:0] a2;
        logic [3:0] m1;
        logic [3:0] m2;
        logic [7:0] re;
    } sched_t;

    sched_t sched [6];

    function automatic sched_t mk(logic aop, logic mop, logic [3:0] a1,
                                  logic [3:0] a2, logic [3:0] m1,
                                  logic [3:0] m2, logic [7:0] re);
        sched_t s;
        s.aop = aop; s.mop = mop; s.a1 = a1; s.a2 = a2;
        s.m1 = m1;   s.m2 = m2;   s.re = re;
        return s;
    endfunction

    function automatic logic [26:0] word_of(sched_t s, logic last);
        return {s.re, s.m2, s.m1, s.a2, s.a1, s.mop, s.aop, last};
    endfunction

    // One cycle of stimulus plus the outputs expected in that cycle.
    typedef struct {
        logic       start;
        logic       stall;
        logic       abort;
        logic       ready;
        logic       res;
        logic       done;
        logic [3:0] step;
        logic       active;   // datapath shows sched[step] this cycle
    } vec_t;

    vec_t vecs [$];

    function automatic void add(logic st, logic sl, logic ab, logic rdy,
                                logic res, logic dn, logic [3:0] step,
                                logic act);
        vec_t v;
        v.start = st; v.stall = sl; v.abort = ab; v.ready = rdy;
        v.res = res;  v.done = dn;  v.step = step; v.active = act;
        vecs.push_back(v);
    endfunction

    // Steps k..5 of the schedule executing one per cycle, no stall.
    function automatic void add_steps(int from);
        for (int s = from; s < 6; s++) begin
            add(0, 0, 0, 0, (s == 5), 0, 4'(s), 1);
        end
    endfunction

    task automatic run_vecs(input int lo, input int hi);
        sched_t e;
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            bus.start = vecs[i].start;
            bus.stall = vecs[i].stall;
            bus.abort = vecs[i].abort;
            #1;
            e = vecs[i].active ? sched[vecs[i].step] : mk(0, 0, 0, 0, 0, 0, 0);
            check($sformatf("vec%0d.op_ready", i),  32'(bus.op_ready),  32'(vecs[i].ready));
            check($sformatf("vec%0d.result_en", i), 32'(bus.result_en), 32'(vecs[i].res));
            check($sformatf("vec%0d.done_next", i), 32'(bus.done_next), 32'(vecs[i].done));
            check($sformatf("vec%0d.step_idx", i),  32'(bus.step_idx),  32'(vecs[i].step));
            check($sformatf("vec%0d.datapath", i),
                  {bus.reg_en, bus.mul1_sel2, bus.mul1_sel1, bus.alu1_sel2,
                   bus.alu1_sel1, bus.mul1_op, bus.alu1_op},
                  {e.re, e.m2, e.m1, e.a2, e.a1, e.mop, e.aop});
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = bus.op_ready;
        end
        check("wait_idle.op_ready", 32'(seen), 32'd1);
    endtask

    int a_lo, a_hi, b_lo, b_hi, c_lo, c_hi;

    initial begin
        sched[0] = mk(0, 0, 4'h0, 4'h0, 4'h0, 4'h1, 8'h01);
        sched[1] = mk(1, 0, 4'h2, 4'h3, 4'h4, 4'h5, 8'h02);
        sched[2] = mk(0, 1, 4'h6, 4'h7, 4'h8, 4'h9, 8'h04);
        sched[3] = mk(1, 1, 4'hA, 4'hB, 4'hC, 4'hD, 8'h08);
        sched[4] = mk(1, 0, 4'hE, 4'hF, 4'h3, 4'h2, 8'h10);
        sched[5] = mk(0, 1, 4'h1, 4'h5, 4'h7, 4'h9, 8'h20);

        // A: plain run. start in cycle 0, steps in 1..6, done 7, idle 8.
        a_lo = vecs.size();
        add(1, 0, 0, 1, 0, 0, 0, 0);
        add_steps(0);
        add(0, 0, 0, 0, 0, 1, 5, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        a_hi = vecs.size();

        // B: three stall cycles at step 2; stall during DONE is ignored.
        b_lo = vecs.size();
        add(1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0, 0, 2, 0);
        add_steps(2);
        add(0, 1, 0, 0, 0, 1, 5, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        b_hi = vecs.size();

        // C: start during RUN ignored, abort at step 3, immediate re-run.
        c_lo = vecs.size();
        add(1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 2, 1);
        add(0, 0, 1, 0, 0, 0, 3, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0);
        add_steps(0);
        add(0, 0, 0, 0, 0, 1, 5, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        c_hi = vecs.size();

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.stall     = 1'b0;
        bus.abort     = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;

        // Reset state.
        #2;
        check("rst.op_ready", 32'(bus.op_ready), 32'd1);
        check("rst.outputs", {bus.result_en, bus.done_next, bus.overrun,
                              bus.prog_err, bus.step_idx, bus.reg_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Program the schedule while idle.
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            bus.prog_we   = 1'b1;
            bus.prog_addr = 4'(s);
            bus.prog_data = word_of(sched[s], (s == 5));
            #1;
            check($sformatf("prog%0d.prog_err", s), 32'(bus.prog_err), 32'd0);
        end
        @(negedge clk);
        bus.prog_we = 1'b0;

        run_vecs(a_lo, a_hi);
        run_vecs(b_lo, b_hi);
`ifdef SCHED_PERF_EN
        check("stall.run_cycles", 32'(bus.run_cycles), 32'd9);
`endif
        run_vecs(c_lo, c_hi);

        // Write attempted during RUN is dropped and flagged for one cycle.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd2;
        bus.prog_data = 27'hABC;
        #1;
        check("runwr.prog_err", 32'(bus.prog_err), 32'd1);
        @(negedge clk);
        bus.prog_we = 1'b0;
        #1;
        check("runwr.prog_err_clear", 32'(bus.prog_err), 32'd0);
        wait_idle(40);
        run_vecs(a_lo, a_hi);   // word 2 must still hold sched[2]

        // Async reset between edges in the middle of a run.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2;
        check("midrun.pre_mul_sel2", 32'(bus.mul1_sel2), 32'h5);
        rst_n = 1'b0;
        #1;
        check("midrun.op_ready", 32'(bus.op_ready), 32'd1);
        check("midrun.outputs", {bus.step_idx, bus.mul1_sel2, bus.reg_en,
                                 bus.alu1_sel1, bus.result_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cleared table: 16 steps with no last flag -> overrun.
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < MAX_STEPS; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            check($sformatf("ovr%0d.step_idx", i), 32'(bus.step_idx), 32'(i));
            check($sformatf("ovr%0d.datapath", i),
                  {bus.reg_en, bus.mul1_sel2, bus.mul1_sel1, bus.alu1_sel2,
                   bus.alu1_sel1, bus.mul1_op, bus.alu1_op}, 32'd0);
            check($sformatf("ovr%0d.result_en", i), 32'(bus.result_en),
                  32'(i == MAX_STEPS - 1));
        end
        @(negedge clk);
        #1;
        check("ovr.done_next", 32'(bus.done_next), 32'd1);
        check("ovr.overrun", 32'(bus.overrun), 32'd1);
`ifdef SCHED_PERF_EN
        check("ovr.run_cycles", 32'(bus.run_cycles), 32'd16);
`endif
        @(negedge clk);
        bus.start = 1'b1;
        #1;
        check("ovr.idle_overrun_held", 32'(bus.overrun), 32'd1);
        check("ovr.idle_op_ready", 32'(bus.op_ready), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("ovr.restart_clears", 32'(bus.overrun), 32'd0);
        // Abort together with stall ends the run at once.
        @(negedge clk);
        bus.stall = 1'b1;
        bus.abort = 1'b1;
        #1;
        check("abst.result_en", 32'(bus.result_en), 32'd0);
        @(negedge clk);
        bus.stall = 1'b0;
        bus.abort = 1'b0;
        #1;
        check("abst.op_ready", 32'(bus.op_ready), 32'd1);
        check("abst.step_idx", 32'(bus.step_idx), 32'd0);
        check("abst.done_next", 32'(bus.done_next), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
